// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types and constants used by the fetch stage.
package cpu_pkg;
    localparam int CPU_XLEN = 32;
    localparam int INSTR_BYTES = 4;
    typedef logic [CPU_XLEN-1:0] word_t;
    localparam word_t CPU_RESET_PC = 32'h0000_0000;
    typedef enum logic [2:0] {BOOT, FETCH, DRAIN, HOLD, FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches over a req/ack port and hands one instruction at a time to decode.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int XLEN = CPU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(CPU_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid,
    output logic            fetch_fault
);
    fetch_state_t r_state, w_nxt_state;
    logic [XLEN-1:0] r_pc, r_pending, r_instr, r_instr_pc;
    logic [XLEN-1:0] w_nxt_pc, w_nxt_pending, w_nxt_instr, w_nxt_instr_pc, w_tgt;
    logic r_valid, r_fault, w_nxt_valid, w_nxt_fault, w_apply;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_pending  <= '0;
            r_instr    <= '0;
            r_instr_pc <= RESET_PC;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_pc       <= w_nxt_pc;
            r_pending  <= w_nxt_pending;
            r_instr    <= w_nxt_instr;
            r_instr_pc <= w_nxt_instr_pc;
            r_valid    <= w_nxt_valid;
            r_fault    <= w_nxt_fault;
        end
    end

    // Every redirect target funnels through w_apply so alignment is checked in one place.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_pc       = r_pc;
        w_nxt_pending  = r_pending;
        w_nxt_instr    = r_instr;
        w_nxt_instr_pc = r_instr_pc;
        w_nxt_valid    = r_valid;
        w_nxt_fault    = r_fault;
        w_apply        = 1'b0;
        w_tgt          = redirect_pc;
        case (r_state)
            BOOT: begin
                w_nxt_state = FETCH;
                w_apply     = redirect;
            end
            FETCH: begin
                if (redirect && imem_ack) begin
                    w_apply = 1'b1;
                end else if (redirect) begin
                    w_nxt_pending = redirect_pc;
                    w_nxt_state   = DRAIN;
                end else if (imem_ack) begin
                    w_nxt_instr    = imem_rdata;
                    w_nxt_instr_pc = r_pc;
                    w_nxt_valid    = 1'b1;
                    w_nxt_state    = HOLD;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    w_apply = 1'b1;
                    w_tgt   = redirect ? redirect_pc : r_pending;
                end else if (redirect) begin
                    w_nxt_pending = redirect_pc;
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_apply = 1'b1;
                end else if (!stall) begin
                    w_nxt_pc    = r_pc + XLEN'(INSTR_BYTES);
                    w_nxt_valid = 1'b0;
                    w_nxt_state = FETCH;
                end
            end
            FAULT: w_apply = redirect;
            default: w_nxt_state = BOOT;
        endcase
        if (w_apply) begin
            w_nxt_pc    = w_tgt;
            w_nxt_valid = 1'b0;
            w_nxt_fault = |w_tgt[1:0];
            w_nxt_state = |w_tgt[1:0] ? FAULT : FETCH;
        end
    end

    assign imem_req    = (r_state == FETCH) || (r_state == DRAIN);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign pc_plus4    = r_instr_pc + XLEN'(INSTR_BYTES);
    assign instr_valid = r_valid;
    assign fetch_fault = r_fault;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios then random traffic, checked every cycle against a transaction-level model.
module tb_fetch_unit;
    logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0, imem_ack = 1'b0;
    logic [31:0] redirect_pc = '0, imem_rdata = '0;
    logic imem_req, instr_valid, fetch_fault;
    logic [31:0] imem_addr, instr, instr_pc, pc_plus4;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int lat = 1, wcnt = 0;
    bit rnd = 0, beef = 0;
    logic [31:0] acked[$];

    // Model: m_addr is the next/outstanding fetch address, m_stale marks a fetch a redirect has orphaned.
    bit m_boot, m_req, m_stale, m_have, m_fault;
    logic [31:0] m_addr, m_target, m_instr, m_ipc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function void m_reset();
        m_boot = 1; m_req = 0; m_stale = 0; m_have = 0; m_fault = 0;
        m_addr = 32'h0; m_target = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
    endfunction

    function void m_go(input logic [31:0] t);
        m_addr = t; m_have = 0; m_stale = 0;
        m_fault = (t[1:0] != 2'b00);
        m_req = !m_fault;
    endfunction

    function void m_step(input bit s, input bit r, input logic [31:0] rpc, input bit a, input logic [31:0] rd);
        if (m_boot) begin
            m_boot = 0;
            if (r) m_go(rpc); else m_req = 1;
        end else if (m_fault) begin
            if (r) m_go(rpc);
        end else if (m_have) begin
            if (r) m_go(rpc);
            else if (!s) begin m_have = 0; m_addr += 32'd4; m_req = 1; end
        end else if (m_req) begin
            if (a) begin
                if (m_stale || r) m_go(r ? rpc : m_target);
                else begin m_have = 1; m_instr = rd; m_ipc = m_addr; m_req = 0; end
            end else if (r) begin
                m_stale = 1; m_target = rpc;
            end
        end
    endfunction

    task automatic compare();
        chk("imem_req", 32'(imem_req), 32'(m_req));
        if (m_req) chk("imem_addr", imem_addr, m_addr);
        chk("instr_valid", 32'(instr_valid), 32'(m_have));
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
        chk("pc_plus4", pc_plus4, m_ipc + 32'd4);
    endtask

    // am: -1 memory decides by latency, 0 force no ack, 1 force ack.
    task automatic tick(input bit s, input bit r, input logic [31:0] rpc, input int am);
        bit req_seen, a;
        req_seen = imem_req;
        a = (am == 1) || (am < 0 && (req_seen ? (wcnt >= lat) : (rnd && $urandom_range(0, 3) == 0)));
        stall = s; redirect = r; redirect_pc = rpc; imem_ack = a;
        imem_rdata = beef ? 32'hDEAD_BEEF : rnd ? $urandom : (imem_addr ^ 32'hA5A5_0000);
        if (a && req_seen) acked.push_back(imem_addr);
        @(posedge clk);
        m_step(s, r, rpc, a, imem_rdata);
        if (req_seen && a) begin wcnt = 0; lat = rnd ? $urandom_range(0, 3) : 1; end
        else if (req_seen) wcnt++;
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b1; redirect = 1'b0;
        #1;
        chk("rst_req_drop", 32'(imem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr_pc", instr_pc, 0);
        m_reset(); wcnt = 0;
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0;
        compare();
    endtask

    task automatic run_until_acks(input int n);
        int i;
        for (i = 0; i < 60 && acked.size() < n; i++) tick(0, 0, 0, -1);
        if (acked.size() < n) begin
            tests++; fails++;
            $display("FAIL ack_timeout: got %0d acks, expected %0d", acked.size(), n);
        end
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compare();
        chk("boot_req", 32'(imem_req), 0);
        chk("boot_valid", 32'(instr_valid), 0);
        chk("boot_instr", instr, 0);
        chk("boot_fault", 32'(fetch_fault), 0);
        // sequential fetch, then stall while holding pc 8
        run_until_acks(3);
        chk("hold_pc", instr_pc, 32'h8);
        chk("hold_instr", instr, 32'hA5A5_0008);
        repeat (5) begin
            tick(1, 0, 0, -1);
            chk("stall_valid", 32'(instr_valid), 1);
            chk("stall_pc", instr_pc, 32'h8);
            chk("stall_req", 32'(imem_req), 0);
        end
        tick(0, 0, 0, -1);
        chk("post_stall_addr", imem_addr, 32'hC);
        run_until_acks(4);
        for (int i = 0; i < 4 && i < acked.size(); i++) chk("addr_seq", acked[i], 32'(i * 4));
        // redirect while the fetch at 0x10 is outstanding
        tick(0, 0, 0, -1);
        chk("req_0x10", imem_addr, 32'h10);
        tick(0, 1, 32'h100, 0);
        chk("drain_addr", imem_addr, 32'h10);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("drain_hold_addr", imem_addr, 32'h10);
        beef = 1;
        tick(0, 0, 0, 1);
        beef = 0;
        chk("drain_done_addr", imem_addr, 32'h100);
        chk("beef_dropped", 32'(instr_valid), 0);
        // redirect coinciding with ack, and redirect in stalled HOLD
        tick(0, 0, 0, 1);
        chk("hold_0x100", instr_pc, 32'h100);
        tick(0, 0, 0, 0);
        tick(0, 1, 32'h200, 1);
        chk("same_cycle_addr", imem_addr, 32'h200);
        chk("same_cycle_valid", 32'(instr_valid), 0);
        tick(1, 0, 0, 1);
        chk("hold_0x200", 32'(instr_valid), 1);
        tick(1, 1, 32'h300, 0);
        chk("hold_redir_valid", 32'(instr_valid), 0);
        chk("hold_redir_addr", imem_addr, 32'h300);
        // misaligned target via DRAIN, then recovery
        tick(0, 1, 32'h102, 0);
        tick(0, 0, 0, 1);
        chk("fault_set", 32'(fetch_fault), 1);
        chk("fault_req", 32'(imem_req), 0);
        tick(0, 1, 32'h103, 0);
        chk("fault_stay", 32'(fetch_fault), 1);
        tick(0, 1, 32'h104, 0);
        chk("fault_clear", 32'(fetch_fault), 0);
        chk("fault_resume", imem_addr, 32'h104);
        // pc wrap
        tick(0, 1, 32'hFFFF_FFFC, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        tick(0, 0, 0, 0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_nofault", 32'(fetch_fault), 0);
        // reset mid-request
        do_reset();
        tick(0, 0, 0, 0);
        chk("reboot_addr", imem_addr, 32'h0);
        chk("reboot_req", 32'(imem_req), 1);
        // random traffic
        rnd = 1;
        lat = $urandom_range(0, 3);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else tick($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                      ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC), -1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
